// File: rtl/ram128_ctrl_pkg.sv
// Shared types and helpers for the RAM128 arbiter/sequencer: state encoding,
// RAM geometry and the byte merge used by read-modify-write.
package ram128_ctrl_pkg;

  localparam int         RAM_AW  = 7;
  localparam int         RAM_DW  = 32;
  localparam logic [3:0] WE_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MERGE,
    RESP
  } state_e;

  // Lanes with their enable set take the new data, the rest keep the old word.
  function automatic logic [RAM_DW-1:0] byte_merge(
    input logic [3:0]        we,
    input logic [RAM_DW-1:0] wdata,
    input logic [RAM_DW-1:0] old
  );
    logic [RAM_DW-1:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = we[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram128_rr_arb.sv
// Two-way round-robin arbiter; on a tie the port not granted last time wins.
module ram128_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (update_i && (|req_i)) begin
      last_d = grant_o[1];
    end
  end

  // Resetting to port 1 hands the first tie to port 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram128_arb_ctrl.sv
// Shares one RAM128 between two requesters and turns partial writes into
// read-modify-write when the macro cannot honour byte enables.
module ram128_arb_ctrl
  import ram128_ctrl_pkg::*;
#(
  parameter bit RMW_EN = 1'b1,
  parameter int WSIZE  = 4
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              p0_req,
  input  logic [WSIZE-1:0]  p0_we,
  input  logic [RAM_AW-1:0] p0_addr,
  input  logic [RAM_DW-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic [WSIZE-1:0]  p1_we,
  input  logic [RAM_AW-1:0] p1_addr,
  input  logic [RAM_DW-1:0] p1_wdata,
  output logic              p0_ack,
  output logic [RAM_DW-1:0] p0_rdata,
  output logic              p1_ack,
  output logic [RAM_DW-1:0] p1_rdata,
  output logic              busy,
  output logic              ram_en,
  output logic [WSIZE-1:0]  ram_we,
  output logic [RAM_AW-1:0] ram_a,
  output logic [RAM_DW-1:0] ram_di,
  input  logic [RAM_DW-1:0] ram_do
);

  localparam logic [WSIZE-1:0] WE_NONE = '0;

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic [WSIZE-1:0]  we_q, we_d;
  logic [RAM_DW-1:0] wdata_q, wdata_d;
  logic              ram_en_q, ram_en_d;
  logic [WSIZE-1:0]  ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_a_q, ram_a_d;
  logic [RAM_DW-1:0] ram_di_q, ram_di_d;
  logic              busy_q, busy_d;

  logic [1:0]             req_vec, grant, ack_vec;
  logic                   sel_port, is_read;
  logic [WSIZE-1:0]       sel_we;
  logic [RAM_AW-1:0]      sel_addr;
  logic [RAM_DW-1:0]      sel_wdata, merged;
  logic [1:0][RAM_DW-1:0] rdata_vec;

  assign req_vec = {p1_req, p0_req};

  ram128_rr_arb u_arb (
    .clk_i   (axi_clk),
    .rst_ni  (axi_reset_n),
    .req_i   (req_vec),
    .update_i(state_q == IDLE),
    .grant_o (grant)
  );

  assign sel_port  = grant[1];
  assign sel_we    = sel_port ? p1_we    : p0_we;
  assign sel_addr  = sel_port ? p1_addr  : p0_addr;
  assign sel_wdata = sel_port ? p1_wdata : p0_wdata;
  assign is_read   = (we_q == WE_NONE);
  assign merged    = byte_merge(we_q, wdata_q, ram_do);

  // RAM strobes are computed one state ahead so they leave a register.
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    ram_en_d = 1'b0;
    ram_we_d = WE_NONE;
    ram_a_d  = ram_a_q;
    ram_di_d = ram_di_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d  = ISSUE;
          port_d   = sel_port;
          we_d     = sel_we;
          wdata_d  = sel_wdata;
          ram_en_d = 1'b1;
          ram_a_d  = sel_addr;
          if ((sel_we != WE_NONE) && ((sel_we == WE_FULL) || !RMW_EN)) begin
            ram_we_d = sel_we;
            ram_di_d = sel_wdata;
          end
        end
      end
      ISSUE: begin
        if (RMW_EN && !is_read && (we_q != WE_FULL)) begin
          state_d  = MERGE;
          ram_en_d = 1'b1;
          ram_we_d = WE_FULL;
        end else begin
          state_d = RESP;
        end
      end
      MERGE: begin
        state_d  = RESP;
        ram_di_d = merged;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      we_q     <= WE_NONE;
      wdata_q  <= '0;
      ram_en_q <= 1'b0;
      ram_we_q <= WE_NONE;
      ram_a_q  <= '0;
      ram_di_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      ram_a_q  <= ram_a_d;
      ram_di_q <= ram_di_d;
      busy_q   <= busy_d;
    end
  end

  // The old word only arrives during MERGE, so the merged data bypasses the register.
  assign ram_di = (state_q == MERGE) ? merged : ram_di_q;
  assign ram_en = ram_en_q;
  assign ram_we = ram_we_q;
  assign ram_a  = ram_a_q;
  assign busy   = busy_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [RAM_DW-1:0] rdata_q;

    assign ack_vec[gi] = (state_q == RESP) && (port_q == 1'(gi));

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
        rdata_q <= '0;
      end else if (ack_vec[gi] && is_read) begin
        rdata_q <= ram_do;
      end
    end

    assign rdata_vec[gi] = (ack_vec[gi] && is_read) ? ram_do : rdata_q;
  end

  assign p0_ack   = ack_vec[0];
  assign p1_ack   = ack_vec[1];
  assign p0_rdata = rdata_vec[0];
  assign p1_rdata = rdata_vec[1];

endmodule

// File: tb/tb_ram128_arb_ctrl.sv
// Directed bench: two controller builds (RMW on/off), each with a behavioural RAM128.
module tb_ram128_arb_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        p0_req, p1_req, p0_ack, p1_ack, busy, ram_en;
  logic [3:0]  p0_we, p1_we, ram_we;
  logic [6:0]  p0_addr, p1_addr, ram_a;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ram_di, ram_do;

  logic        b_req, b_ack, b_p1_ack, b_busy, b_ram_en;
  logic [3:0]  b_we, b_ram_we;
  logic [6:0]  b_addr, b_ram_a;
  logic [31:0] b_wdata, b_rdata, b_p1_rdata, b_ram_di, b_ram_do;

  ram128_arb_ctrl #(.RMW_EN(1'b1), .WSIZE(4)) dut (
    .axi_clk(clk), .axi_reset_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  ram128_arb_ctrl #(.RMW_EN(1'b0), .WSIZE(4)) dut_b (
    .axi_clk(clk), .axi_reset_n(rst_n),
    .p0_req(b_req), .p0_we(b_we), .p0_addr(b_addr), .p0_wdata(b_wdata),
    .p1_req(1'b0), .p1_we(4'h0), .p1_addr(7'h00), .p1_wdata(32'h0),
    .p0_ack(b_ack), .p0_rdata(b_rdata), .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .busy(b_busy), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_a(b_ram_a),
    .ram_di(b_ram_di), .ram_do(b_ram_do)
  );

  // Behavioural RAM128s: byte-enabled write, registered read on every enabled cycle.
  logic [31:0] mem_a [128];
  logic [31:0] mem_b [128];

  always @(posedge clk) begin
    if (ram_en) begin
      ram_do <= mem_a[ram_a];
      for (int b = 0; b < 4; b++) if (ram_we[b]) mem_a[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end
    if (b_ram_en) begin
      b_ram_do <= mem_b[b_ram_a];
      for (int b = 0; b < 4; b++) if (b_ram_we[b]) mem_b[b_ram_a][8*b +: 8] <= b_ram_di[8*b +: 8];
    end
  end

  int          cyc = 0;
  int          n_fw = 0, n_rd = 0, b_pw = 0, b_rd = 0;
  logic [31:0] last_fw = 32'h0;
  logic [3:0]  b_last_we = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_en && ram_we == 4'hF) begin
      n_fw    <= n_fw + 1;
      last_fw <= ram_di;
    end
    if (ram_en && ram_we == 4'h0) n_rd <= n_rd + 1;
    if (b_ram_en && b_ram_we != 4'h0 && b_ram_we != 4'hF) begin
      b_pw      <= b_pw + 1;
      b_last_we <= b_ram_we;
    end
    if (b_ram_en && b_ram_we == 4'h0) b_rd <= b_rd + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits for the next ack on the main instance; lat = -1 on timeout, who = 2 if both fire.
  task automatic wait_ack(input int t0, output int lat, output int who, output logic [31:0] rd);
    lat = -1;
    who = -1;
    rd  = 32'h0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        lat = cyc - t0;
        who = (p0_ack && p1_ack) ? 2 : (p1_ack ? 1 : 0);
        rd  = p1_ack ? p1_rdata : p0_rdata;
        return;
      end
    end
  endtask

  task automatic do_txn(input string tag, input int port, input logic [3:0] we,
                        input logic [6:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rd);
    int t0, lat, who;
    logic [31:0] rd;
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
    t0 = cyc;
    wait_ack(t0, lat, who, rd);
    if (port == 0) p0_req = 1'b0;
    else           p1_req = 1'b0;
    $display("txn %s port=%0d we=%h addr=%h wdata=%h lat=%0d ack_port=%0d rdata=%h",
             tag, port, we, addr, wdata, lat, who, rd);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_port"}, who, port);
    if (we == 4'h0) check_val({tag, "_rdata"}, rd, exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic b_txn(input string tag, input logic [3:0] we, input logic [6:0] addr,
                       input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rd);
    int t0, lat;
    logic [31:0] rd;
    lat = -1;
    rd  = 32'h0;
    b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    t0 = cyc;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b_ack) begin
        lat = cyc - t0;
        rd  = b_rdata;
        break;
      end
    end
    b_req = 1'b0;
    $display("txn %s nomrw we=%h addr=%h wdata=%h lat=%0d rdata=%h", tag, we, addr, wdata, lat, rd);
    check_val({tag, "_lat"}, lat, exp_lat);
    if (we == 4'h0) check_val({tag, "_rdata"}, rd, exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    p0_req = 1'b0; p1_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, who, fw0, rd0, acks;
    logic [31:0] rd;
    p0_req = 1'b0; p0_we = 4'h0; p0_addr = 7'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 4'h0; p1_addr = 7'h0; p1_wdata = 32'h0;
    b_req = 1'b0; b_we = 4'h0; b_addr = 7'h0; b_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_p0_ack", 32'(p0_ack), 32'h0);
    check_val("rst_p1_ack", 32'(p1_ack), 32'h0);
    check_val("rst_p0_rdata", p0_rdata, 32'h0);
    check_val("rst_p1_rdata", p1_rdata, 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_ram_en", 32'(ram_en), 32'h0);
    check_val("rst_ram_we", 32'(ram_we), 32'h0);
    check_val("rst_ram_a", 32'(ram_a), 32'h0);
    check_val("rst_ram_di", ram_di, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write then read back on port 0.
    fw0 = n_fw;
    do_txn("t1_wr", 0, 4'hF, 7'h05, 32'hDEADBEEF, 2, 32'h0);
    check_val("t1_wr_fullwrites", n_fw - fw0, 1);
    fw0 = n_fw;
    do_txn("t1_rd", 0, 4'h0, 7'h05, 32'h0, 2, 32'hDEADBEEF);
    check_val("t1_rd_fullwrites", n_fw - fw0, 0);
    check_val("t1_rdata_hold", p0_rdata, 32'hDEADBEEF);

    // Partial write on port 1 becomes read + full write of the merged word.
    do_txn("t2_pre", 1, 4'hF, 7'h10, 32'h11223344, 2, 32'h0);
    fw0 = n_fw;
    rd0 = n_rd;
    do_txn("t2_rmw", 1, 4'b0101, 7'h10, 32'hAABBCCDD, 3, 32'h0);
    check_val("t2_ram_reads", n_rd - rd0, 1);
    check_val("t2_fullwrites", n_fw - fw0, 1);
    check_val("t2_merged", last_fw, 32'h11BB33DD);
    do_txn("t2_rd", 0, 4'h0, 7'h10, 32'h0, 2, 32'h11BB33DD);

    // Same partial write with byte enables passed straight through.
    b_txn("t3_pre", 4'hF, 7'h10, 32'h11223344, 2, 32'h0);
    rd0 = b_rd;
    b_txn("t3_part", 4'b0101, 7'h10, 32'hAABBCCDD, 2, 32'h0);
    check_val("t3_partial_writes", b_pw, 1);
    check_val("t3_partial_we", 32'(b_last_we), 32'h5);
    check_val("t3_ram_reads", b_rd - rd0, 0);
    b_txn("t3_rd", 4'h0, 7'h10, 32'h0, 2, 32'h11BB33DD);

    // Both ports requesting continuously from reset: strict alternation.
    reset_dut();
    p0_we = 4'h0; p0_addr = 7'h05; p1_we = 4'h0; p1_addr = 7'h10;
    p0_req = 1'b1; p1_req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_ack(t0, lat, who, rd);
      $display("txn alt%0d ack_port=%0d lat=%0d rdata=%h", k, who, lat, rd);
      check_val($sformatf("alt%0d_port", k), who, k % 2);
      check_val($sformatf("alt%0d_lat", k), lat, 2 + 3 * k);
      check_val($sformatf("alt%0d_rdata", k), rd, (k % 2 == 0) ? 32'hDEADBEEF : 32'h11BB33DD);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("alt_busy_idle", 32'(busy), 32'h0);

    // p0 held through its ack while p1 waits: p1 goes next, then p0 again.
    p0_we = 4'h0; p0_addr = 7'h05; p0_req = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    p1_we = 4'h0; p1_addr = 7'h10; p1_req = 1'b1;
    wait_ack(t0, lat, who, rd);
    $display("txn hold0 ack_port=%0d lat=%0d rdata=%h", who, lat, rd);
    check_val("hold0_port", who, 0);
    check_val("hold0_lat", lat, 2);
    wait_ack(t0, lat, who, rd);
    p1_req = 1'b0;
    $display("txn hold1 ack_port=%0d lat=%0d rdata=%h", who, lat, rd);
    check_val("hold1_port", who, 1);
    check_val("hold1_lat", lat, 5);
    check_val("hold1_rdata", rd, 32'h11BB33DD);
    wait_ack(t0, lat, who, rd);
    p0_req = 1'b0;
    $display("txn hold2 ack_port=%0d lat=%0d rdata=%h", who, lat, rd);
    check_val("hold2_port", who, 0);
    check_val("hold2_lat", lat, 8);
    @(posedge clk); #1;

    // Reset lands on entry to MERGE: no ack, strobes drop at once, word unchanged.
    do_txn("t6_clr", 0, 4'hF, 7'h20, 32'h0, 2, 32'h0);
    fw0 = n_fw;
    p0_we = 4'b0001; p0_addr = 7'h20; p0_wdata = 32'h000000FF; p0_req = 1'b1;
    @(posedge clk); #1;
    check_val("t6_issue_busy", 32'(busy), 32'h1);
    check_val("t6_issue_en", 32'(ram_en), 32'h1);
    check_val("t6_issue_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    check_val("t6_merge_we", 32'(ram_we), 32'hF);
    rst_n = 1'b0;
    #1;
    check_val("t6_async_en", 32'(ram_en), 32'h0);
    check_val("t6_async_busy", 32'(busy), 32'h0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (p0_ack || p1_ack) acks++;
    end
    $display("txn t6_abort acks=%0d", acks);
    check_val("t6_no_ack", acks, 0);
    p0_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("t6_fullwrites", n_fw - fw0, 0);
    check_val("t6_rdata_reset", p0_rdata, 32'h0);
    do_txn("t6_rd", 0, 4'h0, 7'h20, 32'h0, 2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
